uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Downstream consumer of the UART receive path: pops bytes from the receiver FIFO read port and assembles framed packets of the form SYNC, LEN, LEN payload bytes, CHK. Payload is held in an internal buffer and released on a valid/ready stream only after the checksum verifies. Corrupt, malformed or stalled frames are dropped with an error pulse, and the parser resynchronises on the next SYNC byte. Backpressure on the output stream propagates to the UART as FIFO occupancy.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload length in bytes (1..255); also the buffer depth.
- TIMEOUT, 50000, inter-byte timeout in clk cycles while inside a frame.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx_empty  input  1  receiver FIFO empty flag.
- r_data  input  8  receiver FIFO head byte; valid whenever rx_empty=0 (show-ahead).
- rd_uart  output  1  FIFO pop; the byte on r_data is consumed at the clock edge where rd_uart=1.
- m_data  output  8  payload byte.
- m_valid  output  1  payload byte valid.
- m_ready  input  1  downstream accepts byte.
- m_last  output  1  marks the final payload byte of a frame.
- frame_ok  output  1  one-cycle pulse: frame accepted.
- frame_err  output  1  one-cycle pulse: frame dropped.
- err_code  output  2  cause of the last drop: 1 bad length, 2 checksum, 3 timeout. Holds its value until the next frame_err.

## Operation
- States: HUNT, LEN, PAYLOAD, CHK, DRAIN.
- rd_uart = !rx_empty && state ∈ {HUNT, LEN, PAYLOAD, CHK}. It is combinational and never asserts in DRAIN.
- HUNT: pops and discards every byte. A popped byte equal to SYNC_BYTE moves to LEN.
- LEN: popped byte L.
  - L==0 or L>MAX_LEN: frame_err, err_code=1, go to HUNT.
  - Otherwise: store L, sum=L, idx=0, go to PAYLOAD.
  - A LEN byte equal to SYNC_BYTE is treated as a length, not a resync.
- PAYLOAD: each popped byte is written to buf[idx], sum+=byte (8-bit, mod 256), idx++. After byte L-1, go to CHK.
- CHK: popped byte compared with sum.
  - Equal: frame_ok, rd_idx=0, go to DRAIN.
  - Not equal: frame_err, err_code=2, go to HUNT.
- DRAIN:
  - m_valid=1, m_data=buf[rd_idx], m_last=(rd_idx==L-1).
  - On m_valid&&m_ready: rd_idx++.
  - On the handshake of the last byte: go to HUNT.
- Timeout:
  - An idle counter runs in LEN, PAYLOAD and CHK. It clears on every pop and on entry to LEN.
  - When it reaches TIMEOUT with no pop: frame_err, err_code=3, go to HUNT.
  - The counter does not run in HUNT or DRAIN. Width is $clog2(TIMEOUT+1).
- A pop in the same cycle the counter reaches TIMEOUT takes priority: the byte is processed and the counter clears.

## Timing
- Reset values: state=HUNT, m_valid=0, m_last=0, m_data=buf[0] (don't-care), frame_ok=0, frame_err=0, err_code=0, rd_uart=0, counters 0. The buffer is not cleared.
- Throughput: one byte consumed per clk while rx_empty=0 in the receiving states.
- frame_ok and frame_err are registered. They are high for exactly the one cycle after the edge that popped the deciding byte, or the edge on which the timeout hit.
- m_valid rises in the same cycle as frame_ok. Latency from CHK pop to first m_valid is 1 cycle.
- Drain rate is one byte per cycle while m_ready=1.
- While m_valid=1 and m_ready=0, m_data and m_last hold stable.
- The first HUNT pop can occur in the cycle after the last drain handshake.
- Reset asserted mid-frame or mid-drain: immediate return to HUNT with outputs at reset values. The partial frame is lost. Bytes still in the FIFO are parsed from HUNT after reset release.

## Test plan
- Good frame with m_ready=1: stream A5 03 11 22 33 69. Required: frame_ok pulses once; m_data 11,22,33 on consecutive cycles; m_last only with 33; err_code stays 0.
- Leading garbage: stream 00 FF 5A, then the good frame above. Required: garbage popped silently, identical output, no frame_err.
- Bad checksum: stream A5 02 10 20 00. Required: frame_err, err_code=2, m_valid never asserts. A following A5 01 07 08 then yields m_data=07 with m_last=1.
- Bad length (MAX_LEN=16): LEN=00, then a separate frame with LEN=11 (17). Required: frame_err with err_code=1 in the cycle after each LEN pop; parser back in HUNT.
- Timeout (TIMEOUT=100): stream A5 02 10, then rx_empty held high. Required: frame_err with err_code=3 exactly 100 cycles after the 10 pop. A byte arriving at cycle 99 prevents the error.
- Backpressure at full length: a 16-byte frame with m_ready toggling 1/0 and more bytes queued in the FIFO. Required: rd_uart=0 throughout DRAIN; m_data held while m_ready=0; all 16 bytes delivered in order with m_last on the 16th.

Source files
------------

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receive FIFO: SYNC, LEN, payload, CHK.
// Buffers the payload and streams it out only once the checksum matches.
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int             AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [7:0]     MAX_L   = 8'(MAX_LEN);

    localparam logic [1:0] E_LEN = 2'd1;
    localparam logic [1:0] E_CHK = 2'd2;
    localparam logic [1:0] E_TO  = 2'd3;

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, DRAIN} state_t;

    state_t        state;
    logic [7:0]    len;
    logic [7:0]    sum;
    logic [7:0]    idx;
    logic [7:0]    rd_idx;
    logic [CW-1:0] idle_cnt;
    logic [7:0]    buf_mem [MAX_LEN];
    logic          pop;
    logic          idle_hit;
    logic          in_frame;

    // No pops while held in reset, so queued bytes survive for HUNT afterwards.
    assign rd_uart  = reset && !rx_empty && (state != DRAIN);
    assign pop      = rd_uart;
    assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CHK);
    assign idle_hit = (idle_cnt == TO_LAST);

    assign m_valid = (state == DRAIN);
    assign m_data  = buf_mem[rd_idx[AW-1:0]];
    assign m_last  = m_valid && (rd_idx == len - 8'd1);

    always_ff @(posedge clk) begin
        if (state == PAYLOAD && pop)
            buf_mem[idx[AW-1:0]] <= r_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            len       <= '0;
            sum       <= '0;
            idx       <= '0;
            rd_idx    <= '0;
            idle_cnt  <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            // A pop on the timeout edge wins: the case below then overrides the drop.
            if (in_frame) begin
                if (pop) begin
                    idle_cnt <= '0;
                end else if (idle_hit) begin
                    idle_cnt  <= '0;
                    frame_err <= 1'b1;
                    err_code  <= E_TO;
                    state     <= HUNT;
                end else begin
                    idle_cnt <= idle_cnt + CW'(1);
                end
            end

            unique case (state)
                HUNT: begin
                    if (pop && r_data == SYNC_BYTE) begin
                        idle_cnt <= '0;
                        state    <= LEN;
                    end
                end
                LEN: begin
                    if (pop) begin
                        if (r_data == 8'd0 || r_data > MAX_L) begin
                            frame_err <= 1'b1;
                            err_code  <= E_LEN;
                            state     <= HUNT;
                        end else begin
                            len   <= r_data;
                            sum   <= r_data;
                            idx   <= '0;
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (pop) begin
                        sum <= sum + r_data;
                        idx <= idx + 8'd1;
                        if (idx == len - 8'd1)
                            state <= CHK;
                    end
                end
                CHK: begin
                    if (pop) begin
                        if (r_data == sum) begin
                            frame_ok <= 1'b1;
                            rd_idx   <= '0;
                            state    <= DRAIN;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= E_CHK;
                            state     <= HUNT;
                        end
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (m_last) begin
                            rd_idx <= '0;
                            state  <= HUNT;
                        end else begin
                            rd_idx <= rd_idx + 8'd1;
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: FIFO model feeding byte streams,
// table of frames with expected payload/status, plus timeout and reset sequences.
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       m_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    uart_frame_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [255:0] stream;
        logic [7:0]   n;
        logic [255:0] pay;
        logic [7:0]   np;
        logic [31:0]  last_mask;
        logic [7:0]   n_ok;
        logic [7:0]   n_err;
        logic [1:0]   code;
        logic [1:0]   rdy;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] got_pay[$];
    logic       got_last[$];
    logic       stall = 1'b0;
    logic [1:0] rdy_mode = 2'd0;
    logic       tog = 1'b0;
    logic       chk_pulse = 1'b1;

    logic       s_valid, s_last, s_fok, s_ferr, s_pop;
    logic [7:0] s_data, s_byte;
    logic [1:0] s_code;
    logic       p_valid, p_ready, p_last, p_pop;
    logic [7:0] p_data;
    int         n_ok, n_err, v_rd, v_hold, v_pulse, v_rise;
    logic [6:0] rst_obs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [255:0] v, input int n, input int i);
        return v[8*(n-1-i) +: 8];
    endfunction

    function automatic vec_t mk(input logic [255:0] stream, input int n, input logic [255:0] pay,
                                input int np, input logic [31:0] lm, input int ok, input int er,
                                input logic [1:0] code, input logic [1:0] rdy);
        vec_t v;
        v.stream = stream; v.n = 8'(n); v.pay = pay; v.np = 8'(np); v.last_mask = lm;
        v.n_ok = 8'(ok); v.n_err = 8'(er); v.code = code; v.rdy = rdy;
        return v;
    endfunction

    task automatic clear_mon();
        n_ok = 0; n_err = 0; v_rd = 0; v_hold = 0; v_pulse = 0; v_rise = 0;
        got_pay.delete(); got_last.delete();
        p_valid = 0; p_ready = 0; p_last = 0; p_pop = 0; p_data = 0; tog = 0;
        s_valid = 0; s_ferr = 0; s_fok = 0; s_code = 0; s_pop = 0;
    endtask

    task automatic cycle();
        @(negedge clk);
        tog = ~tog;
        m_ready  = (rdy_mode == 2'd0) ? 1'b1 : (rdy_mode == 2'd1) ? tog : 1'b0;
        rx_empty = stall || (q.size() == 0);
        r_data   = (q.size() != 0) ? q[0] : 8'h00;
        #1;
        s_valid = m_valid; s_data = m_data; s_last = m_last; s_fok = frame_ok;
        s_ferr = frame_err; s_code = err_code; s_pop = rd_uart; s_byte = r_data;
        if (s_fok) n_ok++;
        if (s_ferr) n_err++;
        if (s_valid ? s_pop : (s_pop != !rx_empty)) v_rd++;
        if (p_valid && !p_ready && (!s_valid || s_data != p_data || s_last != p_last)) v_hold++;
        if (chk_pulse && (s_fok || s_ferr) && !p_pop) v_pulse++;
        if ((s_valid && !p_valid && !s_fok) || (s_fok && !s_valid)) v_rise++;
        if (s_valid && m_ready) begin
            got_pay.push_back(s_data);
            got_last.push_back(s_last);
        end
        p_valid = s_valid; p_ready = m_ready; p_data = s_data; p_last = s_last; p_pop = s_pop;
        @(posedge clk);
        if (s_pop) void'(q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        rx_empty = stall || (q.size() == 0);
        r_data   = (q.size() != 0) ? q[0] : 8'h00;
        #1;
        rst_obs = {m_valid, m_last, frame_ok, frame_err, err_code, rd_uart};
        @(negedge clk);
        reset = 1'b1;
        clear_mon();
    endtask

    task automatic run_idle(input string nm);
        int  idle = 0;
        bit  done = 0;
        for (int c = 0; c < 600; c++) begin
            cycle();
            if (q.size() == 0 && !s_valid) idle++; else idle = 0;
            if (idle >= 3) begin done = 1; break; end
        end
        chk({nm, "_budget"}, 32'(done), 32'd1);
    endtask

    task automatic push(input logic [255:0] s, input int n);
        for (int i = 0; i < n; i++) q.push_back(byte_at(s, n, i));
    endtask

    vec_t tv [8];

    initial begin : main
        logic [31:0] lm;
        bit          found;
        int          early;

        tv[0] = mk({8'hA5,8'h03,8'h11,8'h22,8'h33,8'h69}, 6,
                   {8'h11,8'h22,8'h33}, 3, 32'h4, 1, 0, 2'd0, 2'd0);
        tv[1] = mk({8'h00,8'hFF,8'h5A,8'hA5,8'h03,8'h11,8'h22,8'h33,8'h69}, 9,
                   {8'h11,8'h22,8'h33}, 3, 32'h4, 1, 0, 2'd0, 2'd0);
        tv[2] = mk({8'hA5,8'h02,8'h10,8'h20,8'h00,8'hA5,8'h01,8'h07,8'h08}, 9,
                   {8'h07}, 1, 32'h1, 1, 1, 2'd2, 2'd0);
        tv[3] = mk({8'hA5,8'h00,8'hA5,8'h11}, 4, 256'h0, 0, 32'h0, 0, 2, 2'd1, 2'd0);
        tv[4] = mk({8'hA5,8'hA5,8'hA5,8'h01,8'h33,8'h34}, 6,
                   {8'h33}, 1, 32'h1, 1, 1, 2'd1, 2'd0);
        tv[5] = mk({8'hA5,8'h02,8'hFF,8'h02,8'h03}, 5,
                   {8'hFF,8'h02}, 2, 32'h2, 1, 0, 2'd0, 2'd1);
        tv[6] = mk({8'hA5,8'h01,8'h07,8'h08,8'hA5,8'h02,8'h01,8'h02,8'h05}, 9,
                   {8'h07,8'h01,8'h02}, 3, 32'h5, 2, 0, 2'd0, 2'd0);
        tv[7] = mk({8'hA5,8'h10,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h09,
                    8'h0A,8'h0B,8'h0C,8'h0D,8'h0E,8'h0F,8'h88,8'hA5,8'h01,8'h07,8'h08}, 23,
                   {8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h09,8'h0A,8'h0B,
                    8'h0C,8'h0D,8'h0E,8'h0F,8'h07}, 17, 32'h18000, 2, 0, 2'd0, 2'd1);

        // reset values, with a byte waiting in the FIFO that must not be popped
        q.push_back(8'hA5);
        do_reset();
        chk("rst_outputs", 32'(rst_obs), 32'd0);
        q.delete();

        for (int t = 0; t < 8; t++) begin
            q.delete();
            stall = 0; chk_pulse = 1; rdy_mode = tv[t].rdy;
            do_reset();
            push(tv[t].stream, int'(tv[t].n));
            run_idle($sformatf("v%0d", t));
            chk($sformatf("v%0d_ok", t), 32'(n_ok), 32'(tv[t].n_ok));
            chk($sformatf("v%0d_err", t), 32'(n_err), 32'(tv[t].n_err));
            chk($sformatf("v%0d_code", t), 32'(s_code), 32'(tv[t].code));
            chk($sformatf("v%0d_npay", t), 32'(got_pay.size()), 32'(tv[t].np));
            for (int i = 0; i < int'(tv[t].np) && i < got_pay.size(); i++)
                chk($sformatf("v%0d_pay%0d", t, i), 32'(got_pay[i]),
                    32'(byte_at(tv[t].pay, int'(tv[t].np), i)));
            lm = '0;
            for (int i = 0; i < got_last.size() && i < 32; i++) lm[i] = got_last[i];
            chk($sformatf("v%0d_last", t), lm, tv[t].last_mask);
            chk($sformatf("v%0d_rd_uart", t), 32'(v_rd), 32'd0);
            chk($sformatf("v%0d_hold", t), 32'(v_hold), 32'd0);
            chk($sformatf("v%0d_pulse", t), 32'(v_pulse), 32'd0);
            chk($sformatf("v%0d_vrise", t), 32'(v_rise), 32'd0);
        end

        // timeout fires exactly 100 cycles after the last pop
        q.delete(); stall = 0; chk_pulse = 0; rdy_mode = 2'd0;
        do_reset();
        push({8'hA5,8'h02,8'h10}, 3);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (s_pop && s_byte == 8'h10) begin found = 1; break; end
        end
        chk("to_find", 32'(found), 32'd1);
        early = 0;
        for (int j = 1; j <= 100; j++) begin
            cycle();
            if (s_ferr) early++;
        end
        chk("to_early", 32'(early), 32'd0);
        cycle();
        chk("to_fire", {29'd0, s_ferr, s_code}, {29'd0, 1'b1, 2'd3});
        cycle();
        chk("to_pulse_len", 32'(s_ferr), 32'd0);
        q.push_back(8'hA5);
        cycle();
        chk("to_hunt", 32'(s_pop), 32'd1);

        // a pop on the very edge the counter would expire wins
        q.delete(); stall = 0; chk_pulse = 1;
        do_reset();
        push({8'hA5,8'h02,8'h10,8'h20,8'h32}, 5);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (s_pop && s_byte == 8'h10) begin found = 1; break; end
        end
        stall = 1;
        for (int j = 1; j <= 99; j++) cycle();
        stall = 0;
        cycle();
        chk("to_edge_pop", 32'({found, s_pop, s_ferr}), 32'b110);
        run_idle("to_edge");
        chk("to_edge_err", 32'(n_err), 32'd0);
        chk("to_edge_ok", 32'(n_ok), 32'd1);
        chk("to_edge_npay", 32'(got_pay.size()), 32'd2);

        // reset mid-payload: partial frame lost, leftovers parsed from HUNT
        q.delete(); stall = 0; rdy_mode = 2'd0;
        do_reset();
        push({8'hA5,8'h03,8'h11,8'h22,8'h33,8'h69,8'hA5,8'h01,8'h07,8'h08}, 10);
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (s_pop && s_byte == 8'h22) break;
        end
        do_reset();
        chk("rstpay_outputs", 32'(rst_obs), 32'd0);
        chk("rstpay_fifo", 32'(q.size()), 32'd6);
        run_idle("rstpay");
        chk("rstpay_ok", 32'(n_ok), 32'd1);
        chk("rstpay_err", 32'(n_err), 32'd0);
        chk("rstpay_pay", {23'd0, got_pay.size() == 1, got_pay.size() > 0 ? got_pay[0] : 8'h00},
            {23'd0, 1'b1, 8'h07});

        // reset mid-drain drops the held payload at once
        q.delete(); rdy_mode = 2'd2;
        do_reset();
        push({8'hA5,8'h01,8'h07,8'h08}, 4);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (s_valid) begin found = 1; break; end
        end
        chk("rstdrn_valid", 32'(found), 32'd1);
        do_reset();
        chk("rstdrn_outputs", 32'(rst_obs), 32'd0);
        rdy_mode = 2'd0;
        run_idle("rstdrn");
        chk("rstdrn_npay", 32'(got_pay.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
